grp_buf_rmw_arbiter: RTL and testbench

Generalised successor to the fixed four-channel LCB distributor. It arbitrates N local-commutation channels that want to merge field bits into the write half of the ping-pong orbit group buffer. Each request is executed as a read-modify-write: read the old word, merge under a mask, write it back. The write bank follows the frame former's bank switch, and any in-flight merge that straddles a switch is aborted and retried.

---
 rtl/grp_buf_rmw_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_grp_buf_rmw_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grp_buf_rmw_arbiter.sv
// Round-robin read-modify-write arbiter: N channels merge masked bits into the write
// half of the ping-pong group buffer; a merge straddling a bank switch is aborted and retried.
module grp_buf_rmw_arbiter #(
  parameter int N           = 4,
  parameter int AW          = 10,
  parameter int DW          = 12,
  parameter int RD_LAT      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            swch,
  input  logic [N-1:0]    ch_req,
  input  logic [N*AW-1:0] ch_addr,
  input  logic [N*DW-1:0] ch_data,
  input  logic [N*DW-1:0] ch_mask,
  output logic [N-1:0]    ch_ack,
  output logic            mem_rden,
  output logic [AW-1:0]   mem_rdaddr,
  input  logic [DW-1:0]   mem_q,
  output logic            mem_wren,
  output logic [AW-1:0]   mem_wraddr,
  output logic [DW-1:0]   mem_wrdata,
  output logic            wr_bank,
  output logic            busy,
  output logic [CW-1:0]   wr_count,
  output logic [CW-1:0]   frame_wr_count,
  output logic [CW-1:0]   abort_count
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  localparam logic [2:0] WAIT_LAST = 3'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_swch_prev;
  logic                   r_wr_bank;
  logic [1:0]             r_state;
  logic [2:0]             r_wait_cnt;
  logic [IW-1:0]          r_rr;
  logic [IW-1:0]          r_idx;
  logic [AW-1:0]          r_addr;
  logic [DW-1:0]          r_data;
  logic [DW-1:0]          r_mask;
  logic [AW-1:0]          r_rdaddr;
  logic [AW-1:0]          r_wraddr;
  logic [CW-1:0]          r_wr_count;
  logic [CW-1:0]          r_frame_wr_count;
  logic [CW-1:0]          r_abort_count;

  logic                   w_swch_s;
  logic                   w_sw_evt;
  logic                   w_found;
  logic [IW-1:0]          w_gnt_idx;
  logic                   w_in_wr;

  // Channel index (base + off) modulo N, for the round-robin scan.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  assign w_swch_s = r_sync[SYNC_STAGES-1];
  assign w_sw_evt = w_swch_s ^ r_swch_prev;
  assign w_in_wr  = (r_state == S_WR);

  // NOTE: every always_comb assigns defaults first so no path leaves a variable unassigned (no latch).
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && ch_req[wrap_add(r_rr, k)]) begin
        w_found   = 1'b1;
        w_gnt_idx = wrap_add(r_rr, k);
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync      <= '0;
      r_swch_prev <= 1'b0;
      r_wr_bank   <= 1'b0;
    end else begin
      r_sync[0] <= swch;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_swch_prev <= w_swch_s;
      r_wr_bank   <= ~w_swch_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_wait_cnt       <= '0;
      r_rr             <= '0;
      r_idx            <= '0;
      r_addr           <= '0;
      r_data           <= '0;
      r_mask           <= '0;
      r_rdaddr         <= '0;
      r_wraddr         <= '0;
      r_wr_count       <= '0;
      r_frame_wr_count <= '0;
      r_abort_count    <= '0;
    end else begin
      // A switch restarts the frame count; an aborted write never commits, so it wins.
      if (w_sw_evt) begin
        r_frame_wr_count <= r_wr_count;
        r_wr_count       <= '0;
      end else if (w_in_wr && r_wr_count != '1) begin
        r_wr_count <= r_wr_count + 1'b1;
      end

      if (w_sw_evt && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        if (r_abort_count != '1) r_abort_count <= r_abort_count + 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!w_sw_evt && w_found) begin
              r_idx    <= w_gnt_idx;
              r_addr   <= ch_addr[w_gnt_idx*AW +: AW];
              r_data   <= ch_data[w_gnt_idx*DW +: DW];
              r_mask   <= ch_mask[w_gnt_idx*DW +: DW];
              r_rdaddr <= ch_addr[w_gnt_idx*AW +: AW];
              r_state  <= S_RD;
            end
          end
          S_RD: begin
            if (RD_LAT == 1) begin
              r_wraddr <= r_addr;
              r_state  <= S_WR;
            end else begin
              r_wait_cnt <= '0;
              r_state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (r_wait_cnt == WAIT_LAST) begin
              r_wraddr <= r_addr;
              r_state  <= S_WR;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
          S_WR: begin
            r_rr    <= wrap_add(r_idx, 1);
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign mem_rden       = (r_state == S_RD);
  assign mem_rdaddr     = r_rdaddr;
  assign mem_wren       = w_in_wr && !w_sw_evt;
  assign mem_wraddr     = r_wraddr;
  assign mem_wrdata     = w_in_wr ? ((mem_q & ~r_mask) | (r_data & r_mask)) : '0;
  assign wr_bank        = r_wr_bank;
  assign wr_count       = r_wr_count;
  assign frame_wr_count = r_frame_wr_count;
  assign abort_count    = r_abort_count;

  always_comb begin
    ch_ack = '0;
    if (mem_wren) ch_ack[r_idx] = 1'b1;
  end

endmodule

// File: tb/tb_grp_buf_rmw_arbiter.sv
// Self-checking bench for grp_buf_rmw_arbiter: merge-vector table, directed switch/abort/reset
// sequences, and randomized traffic against a transaction-level round-robin model.
module tb_grp_buf_rmw_arbiter;

  localparam int N           = 4;
  localparam int AW          = 10;
  localparam int DW          = 12;
  localparam int RD_LAT      = 2;
  localparam int SYNC_STAGES = 2;
  localparam int CW          = 11;

  logic            clk = 1'b0;
  logic            reset;
  logic            swch;
  logic [N-1:0]    ch_req;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_data;
  logic [N*DW-1:0] ch_mask;
  logic [N-1:0]    ch_ack;
  logic            mem_rden;
  logic [AW-1:0]   mem_rdaddr;
  logic [DW-1:0]   mem_q;
  logic            mem_wren;
  logic [AW-1:0]   mem_wraddr;
  logic [DW-1:0]   mem_wrdata;
  logic            wr_bank;
  logic            busy;
  logic [CW-1:0]   wr_count;
  logic [CW-1:0]   frame_wr_count;
  logic [CW-1:0]   abort_count;

  grp_buf_rmw_arbiter #(
    .N(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .SYNC_STAGES(SYNC_STAGES), .CW(CW)
  ) u_dut (
    .clk(clk), .reset(reset), .swch(swch),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_data(ch_data), .ch_mask(ch_mask),
    .ch_ack(ch_ack),
    .mem_rden(mem_rden), .mem_rdaddr(mem_rdaddr), .mem_q(mem_q),
    .mem_wren(mem_wren), .mem_wraddr(mem_wraddr), .mem_wrdata(mem_wrdata),
    .wr_bank(wr_bank), .busy(busy),
    .wr_count(wr_count), .frame_wr_count(frame_wr_count), .abort_count(abort_count)
  );

  always #6 clk = ~clk;

  // Two-bank group buffer with RD_LAT read pipeline; poison when no read was issued.
  logic [DW-1:0] tb_mem [2][1<<AW];
  logic [DW-1:0] q_pipe [RD_LAT];
  logic          pl_en;
  logic          pl_bank;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_bank][pl_addr] <= pl_data;
    if (mem_wren) tb_mem[wr_bank][mem_wraddr] <= mem_wrdata;
    q_pipe[0] <= mem_rden ? tb_mem[wr_bank][mem_rdaddr] : DW'(12'hBAD);
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[RD_LAT-1];

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
    logic [DW-1:0] old_word;
    logic [DW-1:0] exp_word;
  } vec_t;

  vec_t vecs [6];

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] t_addr [N];
  logic [DW-1:0] t_data [N];
  logic [DW-1:0] t_mask [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] d,
                                          input logic [DW-1:0] m);
    return (old_w & ~m) | (d & m);
  endfunction

  task automatic drive_ch(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] m);
    ch_addr[ch*AW +: AW] = a;
    ch_data[ch*DW +: DW] = d;
    ch_mask[ch*DW +: DW] = m;
    t_addr[ch] = a;
    t_data[ch] = d;
    t_mask[ch] = m;
  endtask

  task automatic preload(input logic b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_bank = b; pl_addr = a; pl_data = d;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},    ch_ack, 0);
    check({tag, "_rden"},   mem_rden, 0);
    check({tag, "_rdaddr"}, mem_rdaddr, 0);
    check({tag, "_wren"},   mem_wren, 0);
    check({tag, "_wraddr"}, mem_wraddr, 0);
    check({tag, "_wrdata"}, mem_wrdata, 0);
    check({tag, "_bank"},   wr_bank, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_wrcnt"},  wr_count, 0);
    check({tag, "_frcnt"},  frame_wr_count, 0);
    check({tag, "_abcnt"},  abort_count, 0);
  endtask

  task automatic do_reset;
    reset  = 1'b0;
    ch_req = '0;
    tick;
    tick;
    reset = 1'b1;
    repeat (6) tick;
  endtask

  // Issues one request from an idle DUT and checks the full 4-cycle transaction.
  task automatic run_txn(input string tag, input int ch, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m, input logic [DW-1:0] exp_w);
    logic [N-1:0] e;
    e = '0;
    e[ch] = 1'b1;
    drive_ch(ch, a, d, m);
    ch_req[ch] = 1'b1;
    tick;
    check({tag, "_rden"}, mem_rden, 1);
    check({tag, "_rdaddr"}, mem_rdaddr, a);
    check({tag, "_busy"}, busy, 1);
    tick;
    check({tag, "_wait_wren"}, mem_wren, 0);
    tick;
    check({tag, "_wren"}, mem_wren, 1);
    check({tag, "_wraddr"}, mem_wraddr, a);
    check({tag, "_wrdata"}, mem_wrdata, exp_w);
    check({tag, "_ack"}, ch_ack, e);
    ch_req[ch] = 1'b0;
    tick;
    check({tag, "_idle"}, busy, 0);
    check({tag, "_ack_off"}, ch_ack, 0);
  endtask

  // Random-phase model state
  int            rr_m;
  int            free_c;
  int            g_last;
  int            ack_c;
  int            pch;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_word;
  logic [DW-1:0] ref_mem [16];
  logic [N-1:0]  exp_ack;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; swch = 1'b0; ch_req = '0; ch_addr = '0; ch_data = '0; ch_mask = '0;
    pl_en = 1'b0; pl_bank = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < N; i++) begin t_addr[i] = '0; t_data[i] = '0; t_mask[i] = '0; end

    vecs[0] = '{0, 10'h005, 12'h0A0, 12'h0F0, 12'h123, 12'h1A3};
    vecs[1] = '{1, 10'h010, 12'hABC, 12'h000, 12'h5A5, 12'h5A5};
    vecs[2] = '{2, 10'h3FF, 12'h321, 12'hFFF, 12'hDEF, 12'h321};
    vecs[3] = '{3, 10'h000, 12'hFFF, 12'hF0F, 12'h000, 12'hF0F};
    vecs[4] = '{2, 10'h155, 12'h000, 12'h0FF, 12'hFFF, 12'hF00};
    vecs[5] = '{1, 10'h2AA, 12'h555, 12'hAAA, 12'h333, 12'h111};

    tick;
    tick;
    check_all_zero("rst");
    reset = 1'b1;
    repeat (6) tick;
    check("post_rst_bank", wr_bank, 1);

    // Merge vectors, one isolated transaction each
    for (int i = 0; i < 6; i++) begin
      preload(1'b0, vecs[i].addr, vecs[i].old_word);
      preload(1'b1, vecs[i].addr, vecs[i].old_word);
      run_txn($sformatf("vec%0d", i), vecs[i].ch, vecs[i].addr, vecs[i].data, vecs[i].mask,
              vecs[i].exp_word);
      check($sformatf("vec%0d_wrcnt", i), wr_count, CW'(i + 1));
      check($sformatf("vec%0d_mem", i), tb_mem[1][vecs[i].addr], vecs[i].exp_word);
    end

    // Five commits then a switch: counts move to frame_wr_count
    do_reset;
    for (int i = 0; i < 5; i++)
      run_txn($sformatf("frm%0d", i), i % N, AW'(10'h020 + i), DW'(12'h0F0 + i), 12'hFFF,
              DW'(12'h0F0 + i));
    swch = 1'b1;
    tick;
    tick;
    check("frm_evt_wrcnt", wr_count, 5);
    check("frm_evt_bank", wr_bank, 1);
    tick;
    check("frm_frcnt", frame_wr_count, 5);
    check("frm_wrcnt", wr_count, 0);
    check("frm_bank", wr_bank, 0);

    // Round robin with all channels requesting continuously
    do_reset;
    check("rr_start_wrcnt", wr_count, 0);
    for (int i = 0; i < N; i++) drive_ch(i, AW'(10'h040 + i), DW'(12'h100 + i), 12'hFFF);
    ch_req = '1;
    for (int j = 1; j <= 19; j++) begin
      tick;
      exp_ack = '0;
      if (j % 4 == 3) exp_ack[(j / 4) % N] = 1'b1;
      check($sformatf("rr_ack_c%0d", j), ch_ack, exp_ack);
      if (j % 4 == 3) check($sformatf("rr_data_c%0d", j), mem_wrdata, DW'(12'h100 + (j / 4) % N));
    end
    tick;
    ch_req = '0;
    tick;
    check("rr_idle", busy, 0);

    // Switch lands during WAIT of a ch2 merge: abort, then retry into the new bank
    preload(1'b0, 10'h077, 12'hA5A);
    preload(1'b1, 10'h077, 12'hA5A);
    drive_ch(2, 10'h077, 12'h0F0, 12'h0FF);
    ch_req[2] = 1'b1;
    swch = 1'b0;
    tick;
    check("ab_rden", mem_rden, 1);
    tick;
    check("ab_wait_wren", mem_wren, 0);
    check("ab_wait_ack", ch_ack, 0);
    tick;
    check("ab_wren", mem_wren, 0);
    check("ab_ack", ch_ack, 0);
    check("ab_count", abort_count, 1);
    check("ab_busy", busy, 0);
    check("ab_bank", wr_bank, 1);
    check("ab_wrcnt", wr_count, 0);
    check("ab_frcnt", frame_wr_count, 5);
    tick;
    check("ab_retry_rden", mem_rden, 1);
    check("ab_retry_addr", mem_rdaddr, 10'h077);
    tick;
    tick;
    check("ab_retry_wren", mem_wren, 1);
    check("ab_retry_ack", ch_ack, 4'b0100);
    check("ab_retry_data", mem_wrdata, 12'hAF0);
    ch_req[2] = 1'b0;
    tick;
    check("ab_mem_new", tb_mem[1][10'h077], 12'hAF0);
    check("ab_mem_old", tb_mem[0][10'h077], 12'hA5A);
    check("ab_wrcnt_after", wr_count, 1);
    check("ab_count_after", abort_count, 1);

    // ch1 drops its request after the grant and scrambles its inputs
    drive_ch(1, 10'h099, 12'h3C3, 12'hFFF);
    ch_req[1] = 1'b1;
    tick;
    ch_req[1] = 1'b0;
    drive_ch(1, 10'h0AA, 12'h000, 12'h000);
    tick;
    tick;
    check("drop_ack", ch_ack, 4'b0010);
    check("drop_wraddr", mem_wraddr, 10'h099);
    check("drop_wrdata", mem_wrdata, 12'h3C3);
    for (int j = 0; j < 4; j++) begin
      tick;
      check($sformatf("drop_noregrant%0d", j), ch_ack, 0);
      check($sformatf("drop_busy%0d", j), busy, 0);
    end

    // Reset mid-WAIT, then ch3 alone wins from rr=0
    drive_ch(0, 10'h0C0, 12'h111, 12'hFFF);
    ch_req = 4'b0001;
    tick;
    tick;
    check("rw_busy", busy, 1);
    reset  = 1'b0;
    ch_req = 4'b1000;
    drive_ch(3, 10'h0D3, 12'h777, 12'hFFF);
    #1;
    check_all_zero("rw");
    tick;
    tick;
    reset = 1'b1;
    tick;
    check("rw_rden", mem_rden, 1);
    check("rw_rdaddr", mem_rdaddr, 10'h0D3);
    tick;
    tick;
    check("rw_ack", ch_ack, 4'b1000);
    check("rw_wraddr", mem_wraddr, 10'h0D3);
    check("rw_wrdata", mem_wrdata, 12'h777);
    ch_req = '0;
    tick;

    // Randomized traffic against the transaction-level model
    do_reset;
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = DW'($urandom);
      preload(1'b1, AW'(a), ref_mem[a]);
    end
    rr_m = 0; free_c = 0; g_last = -100; ack_c = -1; pch = 0;
    for (int c = 0; c < 620; c++) begin
      tick;
      exp_ack = '0;
      if (c == ack_c) exp_ack[pch] = 1'b1;
      check("rnd_ack", ch_ack, exp_ack);
      check("rnd_wren", mem_wren, c == ack_c);
      check("rnd_busy", busy, (c > g_last) && (c < free_c));
      if (c == ack_c) begin
        check("rnd_wraddr", mem_wraddr, p_addr);
        check("rnd_wrdata", mem_wrdata, p_word);
        ch_req[pch] = 1'b0;
      end
      if (c == g_last + 1) begin
        drive_ch(pch, AW'($urandom_range(0, 15)), DW'($urandom), DW'($urandom));
        if ($urandom_range(0, 3) == 0) ch_req[pch] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (!ch_req[i] && !(c < free_c && i == pch)) begin
          drive_ch(i, AW'($urandom_range(0, 15)), DW'($urandom), DW'($urandom));
          if (c < 560 && $urandom_range(0, 3) == 0) ch_req[i] = 1'b1;
        end
      end
      if (c >= free_c && ch_req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (ch_req[(rr_m + k) % N] && c >= free_c) begin
            pch    = (rr_m + k) % N;
            p_addr = t_addr[pch];
            p_word = merge(ref_mem[p_addr[3:0]], t_data[pch], t_mask[pch]);
            ref_mem[p_addr[3:0]] = p_word;
            g_last = c;
            ack_c  = c + 3;
            free_c = c + 4;
            rr_m   = (pch + 1) % N;
          end
        end
      end
    end
    ch_req = '0;
    repeat (4) tick;
    for (int a = 0; a < 16; a++) check($sformatf("rnd_mem%0d", a), tb_mem[1][a], ref_mem[a]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
